// File: rtl/apb_pkg.sv
// Shared APB definitions: transfer FSM states and default bus widths.
package apb_pkg;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requester at or after last_grant+1, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    index,
  output logic               any
);

  always_comb begin
    int c;
    grant = '0;
    index = '0;
    any   = 1'b0;
    c     = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      c = (int'(last_grant) + i) % NUM_REQ;
      if (!any && req[c]) begin
        any      = 1'b1;
        grant[c] = 1'b1;
        index    = ID_W'(c);
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Multi-requester APB requester: round-robin grant, one SETUP/ACCESS transfer
// at a time, wait-state timeout, one-cycle registered completion pulse.
//
// state     | meaning
// ST_IDLE   | bus quiet, arbitrate and latch the granted command
// ST_SETUP  | psel high, penable low
// ST_ACCESS | psel and penable high, waiting for pready or timeout
module apb_req_arbiter
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = APB_ADDR_W,
  parameter int DATA_WIDTH = APB_DATA_W,
  parameter int NUM_REQ    = 2,
  parameter int TIMEOUT    = 16,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                          pclk,
  input  logic                          preset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic                          rsp_valid,
  output logic [ID_W-1:0]               rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic                          psel,
  output logic                          penable,
  output logic                          pwrite,
  output logic [ADDR_WIDTH-1:0]         paddr,
  output logic [DATA_WIDTH-1:0]         pwdata,
  input  logic [DATA_WIDTH-1:0]         prdata,
  input  logic                          pready,
  input  logic                          pslverr
);

  apb_state_e          state;
  logic [ID_W-1:0]     last_grant;
  logic [7:0]          wait_cnt;
  logic [NUM_REQ-1:0]  gnt_onehot;
  logic [ID_W-1:0]     gnt_idx;
  logic                gnt_any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (gnt_onehot),
    .index      (gnt_idx),
    .any        (gnt_any)
  );

  assign req_ready = (state == ST_IDLE) ? gnt_onehot : '0;

  // The bus registers double as the latched command; they are zeroed on
  // every return to IDLE so the idle bus reads all-zero.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state      <= ST_IDLE;
      last_grant <= ID_W'(NUM_REQ - 1);
      wait_cnt   <= '0;
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (gnt_any) begin
            last_grant <= gnt_idx;
            psel       <= 1'b1;
            pwrite     <= req_write[gnt_idx];
            paddr      <= req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            pwdata     <= req_wdata[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
            state      <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          penable  <= 1'b1;
          wait_cnt <= '0;
          state    <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (pready || wait_cnt == 8'(TIMEOUT - 1)) begin
            rsp_valid <= 1'b1;
            rsp_id    <= last_grant;
            rsp_err   <= pready ? pslverr : 1'b1;
            rsp_rdata <= (pready && !pwrite) ? prdata : '0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            wait_cnt  <= '0;
            state     <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/apb_req_arbiter.md
APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, APB address width.
REQ-002 Parameter DATA_WIDTH, default 16, APB data width.
REQ-003 Parameter NUM_REQ, default 2, number of requesters (legal range 2..8); ID_W = clog2(NUM_REQ).
REQ-004 Parameter TIMEOUT, default 16, maximum ACCESS-phase cycles before abort (legal range 2..255).
REQ-005 pclk  in  1  clock; all state changes on rising edge.
REQ-006 preset  in  1  reset, asynchronous, active-high.
REQ-007 req_valid  in  NUM_REQ  per-requester command valid.
REQ-008 req_ready  out  NUM_REQ  per-requester command accepted (one-hot or zero).
REQ-009 req_write  in  NUM_REQ  1 = write, 0 = read.
REQ-010 req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at slice i.
REQ-011 req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
REQ-012 rsp_valid  out  1  one-cycle completion pulse.
REQ-013 rsp_id  out  ID_W  requester index of completed transfer.
REQ-014 rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and aborts.
REQ-015 rsp_err  out  1  pslverr or timeout.
REQ-016 psel, penable, pwrite  out  1 each; paddr  out  ADDR_WIDTH; pwdata  out  DATA_WIDTH  APB requester-side bus.
REQ-017 prdata  in  DATA_WIDTH; pready, pslverr  in  1  APB completer-side bus.

Function
REQ-018 FSM states IDLE, SETUP, ACCESS shall be implemented.
REQ-019 IDLE: if any req_valid high, the grant shall be the first valid index searching from last_grant+1 (mod NUM_REQ); req_ready[grant] high combinationally that cycle; write, addr, wdata latched; next state SETUP.
REQ-020 req_ready shall be zero outside IDLE and whenever no req_valid is high.
REQ-021 last_grant shall update only on a grant in IDLE.
REQ-022 SETUP: psel=1, penable=0, paddr/pwrite/pwdata from latched command; next state ACCESS unconditionally.
REQ-023 ACCESS: psel=1, penable=1, bus outputs held stable; a wait counter increments each cycle pready is low.
REQ-024 ACCESS with pready=1: the next cycle shall have rsp_valid=1, rsp_id=grant, rsp_err=pslverr, and rsp_rdata=prdata for reads (0 for writes); state returns to IDLE.
REQ-025 ACCESS with pready=0 on the TIMEOUT-th ACCESS cycle: the transfer shall abort; the next cycle shall have rsp_valid=1, rsp_err=1, rsp_rdata=0; state IDLE.
REQ-026 In IDLE, psel, penable, pwrite, paddr and pwdata shall be 0.
REQ-027 Minimum transfer spacing shall be 3 cycles (IDLE, SETUP, ACCESS); back-to-back requests incur no further bubbles.
REQ-028 Requester commands that change while not granted shall be ignored; pslverr shall be ignored unless pready=1.

Reset
REQ-029 On preset: state IDLE; last_grant=NUM_REQ-1 (requester 0 wins first); wait counter 0; all outputs 0.
REQ-030 preset asserted mid-transfer shall drop psel/penable immediately (asynchronously), and no rsp_valid shall be produced for the killed transfer.

Structure
REQ-031 The FSM state enum and the default ADDR_WIDTH/DATA_WIDTH constants shall live in shared package apb_pkg.
REQ-032 The round-robin grant logic shall be a sub-module rr_arbiter (inputs req vector, last_grant; outputs one-hot grant, index, any).

Verification
REQ-033 Single read: req_valid=01, addr 0x10, pready held 1, prdata 0xBEEF -> psel rises 1 cycle after grant, penable next, rsp_valid with id 0, rdata 0xBEEF, err 0.
REQ-034 Contention: both valid continuously, 4 transfers -> grants 0,1,0,1; rsp_id sequence matches; 3-cycle spacing.
REQ-035 Wait states: write addr 0x22, data 0x1234, pready low 3 cycles -> ACCESS lasts 4 cycles, paddr/pwdata stable, rsp_err 0, rsp_rdata 0.
REQ-036 Slave error: read with pslverr=1 at pready -> rsp_err 1, rsp_rdata = prdata.
REQ-037 Timeout: pready stuck 0, TIMEOUT=16 -> exactly 16 ACCESS cycles, rsp_err 1, rsp_rdata 0, FSM IDLE.
REQ-038 Reset in ACCESS: assert preset during wait -> psel/penable 0 same cycle, no rsp_valid; after release requester 0 wins first.
